// File: rtl/pcileech_tlps128_dwrd_requester_pkg.sv
// Shared definitions for the single-DWORD MRd requester.
//   state_t      : requester FSM states
//   FT_*         : TLP Fmt/Type[4:1] codes as seen in tdata[31:25]
//   CPL_*        : completion status codes
//   ERR_DATA     : data returned on any failed read
package pcileech_tlps128_dwrd_requester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    WAIT
  } state_t;

  localparam logic [6:0]  FT_MRD32  = 7'b0000000;
  localparam logic [6:0]  FT_CPL    = 7'b0000101;
  localparam logic [6:0]  FT_CPLD   = 7'b0100101;

  // MRd32 header DW0: Fmt/Type MRd32, all attributes zero, length 1 DW
  localparam logic [31:0] MRD32_DW0 = {FT_MRD32, 1'b0, 14'h0000, 10'd1};

  localparam logic [2:0]  CPL_SC    = 3'b000;
  localparam logic [2:0]  CPL_UR    = 3'b001;
  localparam logic [2:0]  CPL_CRS   = 3'b010;
  localparam logic [2:0]  CPL_CA    = 3'b100;

  localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;

endpackage

// File: rtl/IfAXIS128.sv
// 128-bit AXI-Stream TLP interface.
//   source    : TLP producer (drives everything except tready)
//   sink      : TLP consumer with backpressure
//   sink_lite : snooping consumer, no backpressure
interface IfAXIS128;
  logic [127:0] tdata;
  logic [3:0]   tkeepdw;
  logic         tvalid;
  logic         tlast;
  logic [8:0]   tuser;
  logic         tready;
  logic         has_data;

  modport source    (output tdata, tkeepdw, tvalid, tlast, tuser, has_data, input tready);
  modport sink      (input tdata, tkeepdw, tvalid, tlast, tuser, has_data, output tready);
  modport sink_lite (input tdata, tkeepdw, tvalid, tlast, tuser, has_data);
endinterface

// File: rtl/pcileech_tlps128_cpl_match.sv
// Combinational completion decode and compare.
//   tdata/tvalid/tuser0 : snooped rx beat
//   in_wait             : requester is waiting for its completion
//   exp_tag, pcie_id    : tag and requester ID of the outstanding read
//   cpl_seen            : beat is a Cpl or CplD
//   cpl_match           : completion belongs to the outstanding read
//   cpl_ok              : successful CplD (data usable)
//   cpl_data            : first payload DW
module pcileech_tlps128_cpl_match
  import pcileech_tlps128_dwrd_requester_pkg::*;
(
  input  logic [127:0] tdata,
  input  logic         tvalid,
  input  logic         tuser0,
  input  logic         in_wait,
  input  logic [7:0]   exp_tag,
  input  logic [15:0]  pcie_id,
  output logic         cpl_seen,
  output logic         cpl_match,
  output logic         cpl_ok,
  output logic [31:0]  cpl_data
);

  logic is_cpl;
  logic is_cpld;
  logic unused_hdr_bits;

  assign is_cpl    = (tdata[31:25] == FT_CPL);
  assign is_cpld   = (tdata[31:25] == FT_CPLD);
  assign cpl_seen  = tvalid & tuser0 & (is_cpl | is_cpld);
  assign cpl_match = cpl_seen & in_wait &
                     (tdata[79:72] == exp_tag) & (tdata[95:80] == pcie_id);
  assign cpl_ok    = is_cpld & (tdata[47:45] == CPL_SC);
  assign cpl_data  = tdata[127:96];

  assign unused_hdr_bits = ^{tdata[71:48], tdata[44:32], tdata[24:0]};

endmodule

// File: rtl/pcileech_tlps128_dwrd_requester.sv
// Single-DWORD memory read requester: accepts one request at a time,
// emits an MRd32 TLP, and waits for the matching completion.
// Optional feature: define PCILEECH_DWRD_TIMEOUT_EN to abort a read
// after TIMEOUT_CYCLES cycles in WAIT with an error response.
//   clk_pcie, rst          : clock, async active-high reset
//   pcie_id                : requester ID of this core
//   req_valid/req_ready    : request handshake (req_addr DW address, req_be)
//   tlps_tx                : MRd TLP output
//   tlps_rx                : snooped incoming TLPs
//   rsp_valid/data/err     : one-cycle response pulse
//   drop_cnt               : saturating count of unmatched completions
module pcileech_tlps128_dwrd_requester
  import pcileech_tlps128_dwrd_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter logic [7:0]  TAG_BASE       = 8'h80
)(
  input  logic          clk_pcie,
  input  logic          rst,
  input  logic [15:0]   pcie_id,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [29:0]   req_addr,
  input  logic [3:0]    req_be,
  IfAXIS128.source      tlps_tx,
  IfAXIS128.sink_lite   tlps_rx,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic [7:0]    drop_cnt
);

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [7:0]  tag_out;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic        tx_hs;
  logic        expire;
  logic        cpl_seen, cpl_match, cpl_ok;
  logic [31:0] cpl_data;
  logic [7:0]  tag_cur;
  logic        unused_rx_bits;

  assign tag_cur   = {TAG_BASE[7:5], cnt};
  assign req_ready = (state == IDLE);
  assign tx_hs     = (state == TX) & tlps_tx.tready;

  assign tlps_tx.tvalid   = (state == TX);
  assign tlps_tx.has_data = (state == TX);
  assign tlps_tx.tdata    = {32'h0000_0000, addr_q, 2'b00,
                             pcie_id, tag_cur, 4'b0000, be_q, MRD32_DW0};
  assign tlps_tx.tkeepdw  = 4'b0111;
  assign tlps_tx.tlast    = 1'b1;
  assign tlps_tx.tuser    = '0;

  assign unused_rx_bits = ^{tlps_rx.tkeepdw, tlps_rx.tlast,
                            tlps_rx.tuser[8:1], tlps_rx.has_data};

  pcileech_tlps128_cpl_match u_cpl_match (
    .tdata     (tlps_rx.tdata),
    .tvalid    (tlps_rx.tvalid),
    .tuser0    (tlps_rx.tuser[0]),
    .in_wait   (state == WAIT),
    .exp_tag   (tag_out),
    .pcie_id   (pcie_id),
    .cpl_seen  (cpl_seen),
    .cpl_match (cpl_match),
    .cpl_ok    (cpl_ok),
    .cpl_data  (cpl_data)
  );

`ifdef PCILEECH_DWRD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counter is zero in the first WAIT cycle; the last cycle in which a
  // completion is still accepted is TIMEOUT_CYCLES-1.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (tx_hs)         tmo_cnt <= '0;
    else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign expire = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)             state_nx = TX;
      TX:      if (tlps_tx.tready)        state_nx = WAIT;
      WAIT:    if (cpl_match || expire)   state_nx = IDLE;
      default:                            state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tag_out  <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      drop_cnt <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        be_q   <= req_be;
      end
      if (tx_hs) begin
        tag_out <= tag_cur;
        cnt     <= cnt + 5'd1;
      end
      if (cpl_seen && !cpl_match && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Match wins over a simultaneous timeout expiry.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= cpl_match | expire;
      if (cpl_match) begin
        rsp_data <= cpl_ok ? cpl_data : ERR_DATA;
        rsp_err  <= ~cpl_ok;
      end else if (expire) begin
        rsp_data <= ERR_DATA;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcileech_tlps128_dwrd_requester.sv
module tb_pcileech_tlps128_dwrd_requester;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pcie_id = 16'h0100;
  logic        req_valid = 1'b0;
  logic [29:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  drop_cnt;

  IfAXIS128 tx_if();
  IfAXIS128 rx_if();

  always #5 clk = ~clk;

  pcileech_tlps128_dwrd_requester #(.TIMEOUT_CYCLES(TMO), .TAG_BASE(8'h80)) dut (
    .clk_pcie  (clk),
    .rst       (rst),
    .pcie_id   (pcie_id),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .tlps_tx   (tx_if),
    .tlps_rx   (rx_if),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .drop_cnt  (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  // One read in flight: "sending" until the TLP is accepted, then "waiting"
  // until its completion arrives (or, with the timeout build, until
  // TMO cycles have elapsed since the wait began).
  int unsigned cyc = 0, m_wstart = 0, m_ctr = 0, m_drops = 0;
  bit          m_send = 0, m_wait = 0;
  logic [29:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic [7:0]  m_tag = '0;
  bit          e_rv = 0, e_re = 0;
  logic [31:0] e_rd = '0;
  bit          m_idle, m_cpld, m_cplx, m_seen, m_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_wstart = 0; m_ctr = 0; m_drops = 0;
      m_send = 0; m_wait = 0; e_rv = 0; e_re = 0; e_rd = '0;
    end else begin
      m_idle = !m_send && !m_wait;
      e_rv   = 0;
      m_cpld = (rx_if.tdata[31:24] == 8'h4A);
      m_cplx = (rx_if.tdata[31:24] == 8'h0A);
      m_seen = rx_if.tvalid && rx_if.tuser[0] && (m_cpld || m_cplx);
      m_hit  = m_seen && m_wait && rx_if.tdata[79:72] == m_tag &&
               rx_if.tdata[95:80] == pcie_id;
      if (m_seen && !m_hit && m_drops < 255) m_drops++;
      if (m_hit) begin
        e_rv = 1;
        m_wait = 0;
        if (m_cpld && rx_if.tdata[47:45] == 3'd0) begin
          e_rd = rx_if.tdata[127:96]; e_re = 0;
        end else begin
          e_rd = 32'hFFFF_FFFF; e_re = 1;
        end
      end
`ifdef PCILEECH_DWRD_TIMEOUT_EN
      else if (m_wait && (cyc - m_wstart) == TMO - 1) begin
        e_rv = 1; m_wait = 0; e_rd = 32'hFFFF_FFFF; e_re = 1;
      end
`endif
      if (m_send && tx_if.tready) begin
        m_send = 0; m_wait = 1; m_wstart = cyc + 1; m_ctr = (m_ctr + 1) % 32;
      end else if (m_idle && req_valid) begin
        m_send = 1; m_addr = req_addr; m_be = req_be; m_tag = 8'h80 | 8'(m_ctr);
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, !m_send && !m_wait);
      chk("tx_tvalid", tx_if.tvalid, m_send);
      if (m_send) begin
        chk("tx_tdata", tx_if.tdata,
            {32'h0, m_addr, 2'b00, pcie_id, m_tag, 4'h0, m_be, 32'h0000_0001});
        chk("tx_ctrl", {tx_if.tkeepdw, tx_if.tlast, tx_if.tuser, tx_if.has_data},
            {4'b0111, 1'b1, 9'h000, 1'b1});
      end
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_data", rsp_data, e_rd);
        chk("rsp_err", rsp_err, e_re);
      end
      chk("drop_cnt", drop_cnt, 8'(m_drops));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns one cycle after the request handshake (DUT in TX).
  task automatic send_req(input logic [29:0] a, input logic [3:0] be);
    int n = 0;
    req_addr = a; req_be = be; req_valid = 1'b1;
    while (!req_ready && n < 300) begin tick(); n++; end
    chk("req_accept_bound", n < 300, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic cpl(input logic [6:0] ft, input logic [2:0] st, input logic [15:0] rid,
                     input logic [7:0] tag, input logic [31:0] data, input logic tu);
    rx_if.tdata   = {data, rid, tag, 8'h00, 16'h0000, st, 1'b0, 12'h004,
                     ft, 1'b0, 24'h000001};
    rx_if.tuser   = {8'h00, tu};
    rx_if.tkeepdw = 4'hF;
    rx_if.tlast   = 1'b1;
    rx_if.has_data = 1'b1;
    rx_if.tvalid  = 1'b1;
    tick();
    rx_if.tvalid  = 1'b0;
    rx_if.tuser   = '0;
  endtask

  task automatic wait_rsp(input int limit, output int n, output logic ok,
                          output logic [31:0] d, output logic e);
    n = 0;
    while (!rsp_valid && n < limit) begin tick(); n++; end
    ok = rsp_valid; d = rsp_data; e = rsp_err;
  endtask

  localparam logic [6:0] CPLD = 7'b0100101;
  localparam logic [6:0] CPLN = 7'b0000101;

  logic [127:0] td;
  logic [31:0]  d;
  logic         e, ok;
  int           n;
  logic [7:0]   etag;

  initial begin
    tx_if.tready = 1'b1;
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tuser = '0;
    rx_if.tkeepdw = '0; rx_if.tlast = 1'b0; rx_if.has_data = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_tvalid", tx_if.tvalid, 1'b0);

    // basic read
    send_req(30'h0400, 4'hF);
    td = tx_if.tdata;
    chk("basic_dw0", td[31:0], 32'h0000_0001);
    chk("basic_dw1", td[63:32], 32'h0100_800F);
    chk("basic_dw2", td[95:64], 32'h0000_1000);
    repeat (10) tick();
    cpl(CPLD, 3'd0, 16'h0100, 8'h80, 32'hDEAD_BEEF, 1'b1);
    wait_rsp(20, n, ok, d, e);
    chk("basic_rsp_seen", ok, 1'b1);
    chk("basic_rsp_data", d, 32'hDEAD_BEEF);
    chk("basic_rsp_err", e, 1'b0);

    // backpressure, plus a completion during TX and a non-completion beat
    tx_if.tready = 1'b0;
    send_req(30'h0ABC_DEF, 4'h3);
    cpl(CPLD, 3'd0, 16'h0100, 8'h81, 32'h1111_1111, 1'b1);
    cpl(CPLD, 3'd0, 16'h0100, 8'h99, 32'h2222_2222, 1'b0);
    repeat (3) tick();
    chk("bp_tlp", tx_if.tdata,
        {32'h0, 32'h02AF_37BC, 32'h0100_8103, 32'h0000_0001});
    chk("bp_ready_low", req_ready, 1'b0);
    chk("bp_drop_tx", drop_cnt, 8'h01);
    tx_if.tready = 1'b1;
    tick();
    chk("bp_tvalid_clr", tx_if.tvalid, 1'b0);
    cpl(CPLN, 3'b001, 16'h0100, 8'h81, 32'h0, 1'b1);
    wait_rsp(20, n, ok, d, e);
    chk("ur_rsp_seen", ok, 1'b1);
    chk("ur_rsp_data", d, 32'hFFFF_FFFF);
    chk("ur_rsp_err", e, 1'b1);

    // reset while waiting: no response, late completion is a drop
    send_req(30'h0055, 4'h1);
    tick();
    do_reset();
    chk("midrst_ready", req_ready, 1'b1);
    repeat (3) tick();
    cpl(CPLD, 3'd0, 16'h0100, 8'h82, 32'h3333_3333, 1'b1);
    tick();
    chk("midrst_late_drop", drop_cnt, 8'h01);
    do_reset();

    // drops: wrong tag, foreign requester, then the real completion
    send_req(30'h0001, 4'hF);
    tick();
    cpl(CPLD, 3'd0, 16'h0100, 8'h85, 32'h4444_4444, 1'b1);
    cpl(CPLD, 3'd0, 16'h0200, 8'h80, 32'h5555_5555, 1'b1);
    chk("drops_two", drop_cnt, 8'h02);
    chk("drops_no_rsp", rsp_valid, 1'b0);
    cpl(CPLD, 3'd0, 16'h0100, 8'h80, 32'hCAFE_F00D, 1'b1);
    wait_rsp(20, n, ok, d, e);
    chk("drops_match_data", d, 32'hCAFE_F00D);
    cpl(CPLD, 3'd0, 16'h0100, 8'h80, 32'h6666_6666, 1'b1);
    for (int i = 0; i < 300; i++) cpl(CPLN, 3'd0, 16'hFFFF, 8'h00, 32'h0, 1'b1);
    chk("drop_saturate", drop_cnt, 8'hFF);
    do_reset();

    // tag wrap; one CplD with CA status on the way
    for (int i = 0; i < 34; i++) begin
      etag = 8'h80 | 8'(i % 32);
      send_req(30'(i), 4'hF);
      chk("wrap_tag", tx_if.tdata[47:40], etag);
      tick();
      cpl(CPLD, (i == 5) ? 3'b100 : 3'b000, 16'h0100, etag, 32'h1000 + 32'(i), 1'b1);
      wait_rsp(20, n, ok, d, e);
      chk("wrap_rsp_seen", ok, 1'b1);
      chk("wrap_rsp_data", d, (i == 5) ? 32'hFFFF_FFFF : 32'h1000 + 32'(i));
    end

`ifdef PCILEECH_DWRD_TIMEOUT_EN
    do_reset();
    // no completion: response in WAIT-relative cycle 64
    send_req(30'h0077, 4'hF);
    tick();
    wait_rsp(200, n, ok, d, e);
    chk("tmo_seen", ok, 1'b1);
    chk("tmo_cycle", n, 64);
    chk("tmo_err", e, 1'b1);
    chk("tmo_data", d, 32'hFFFF_FFFF);
    // completion in the last accepted cycle beats expiry
    send_req(30'h0078, 4'hF);
    tick();
    repeat (63) tick();
    cpl(CPLD, 3'd0, 16'h0100, 8'h81, 32'h7777_7777, 1'b1);
    wait_rsp(5, n, ok, d, e);
    chk("tmo_edge_err", e, 1'b0);
    chk("tmo_edge_data", d, 32'h7777_7777);
    // reset in WAIT: nothing comes out afterwards
    send_req(30'h0079, 4'hF);
    repeat (6) tick();
    do_reset();
    chk("tmo_rst_ready", req_ready, 1'b1);
    repeat (80) tick();
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
